load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, 9, memory word-address width.
REQ-002 The block SHALL have parameter DATA_W, 32, memory word width.
REQ-003 The block SHALL have parameter TAG_W, 4, load destination tag width.
REQ-004 The block SHALL have port clock  in  1  sole clock; all state updates on posedge.
REQ-005 The block SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port req_valid  in  1  request present.
REQ-007 The block SHALL have port req_ready  out  1  request accepted when req_valid && req_ready at posedge.
REQ-008 The block SHALL have port req_write  in  1  1 = store, 0 = load.
REQ-009 The block SHALL have port req_half  in  1  1 = 16-bit access, 0 = full word.
REQ-010 The block SHALL have port req_hi  in  1  half select: 1 = bits 31:16, 0 = bits 15:0.
REQ-011 The block SHALL have port req_signed  in  1  sign-extend half loads.
REQ-012 The block SHALL have port req_addr  in  ADDR_W  word address.
REQ-013 The block SHALL have port req_wdata  in  DATA_W  store data; half stores use bits 15:0.
REQ-014 The block SHALL have port req_tag  in  TAG_W  load tag, returned with the response.
REQ-015 The block SHALL have port resp_valid  out  1  load result valid.
REQ-016 The block SHALL have port resp_ready  in  1  consumer takes result.
REQ-017 The block SHALL have ports resp_rdata  out  DATA_W and resp_tag  out  TAG_W  load result and tag.
REQ-018 The block SHALL have ports mem_rd_addr  out  ADDR_W and mem_rd_data  in  DATA_W  combinational read port.
REQ-019 The block SHALL have ports mem_wr_addr  out  ADDR_W, mem_wr_data  out  DATA_W, mem_wr_enable  out  1  registered write port.
REQ-020 The block SHALL have ports n_loads and n_stores  out  16 each  saturating statistic counters.

Function
REQ-021 The FSM SHALL have two states: IDLE and WRITE.
REQ-022 req_ready SHALL equal (state==IDLE) && (!resp_valid || resp_ready).
REQ-023 mem_rd_addr SHALL equal req_addr combinationally in every cycle.
REQ-024 An accepted word load SHALL register resp_rdata=mem_rd_data and resp_tag=req_tag, and set resp_valid, at the accepting edge; latency is 1 cycle.
REQ-025 An accepted half load SHALL return the selected half, zero-extended or sign-extended from bit 15 per req_signed.
REQ-026 resp_valid, resp_rdata and resp_tag SHALL hold stable until resp_ready; resp_valid SHALL clear on resp_ready unless a new load is accepted in the same cycle.
REQ-027 An accepted word store SHALL register mem_wr_addr=req_addr, mem_wr_data=req_wdata, mem_wr_enable=1, and enter WRITE.
REQ-028 An accepted half store SHALL read-modify-write: merge req_wdata[15:0] into the selected half of mem_rd_data, leave the other half unchanged, then register the write as for a word store.
REQ-029 WRITE SHALL last exactly one cycle with mem_wr_enable=1, then return to IDLE with mem_wr_enable=0; no request is accepted in WRITE, so a following load always sees stored data.
REQ-030 Stores SHALL produce no response, and a store SHALL be accepted while an earlier load response is still pending only if req_ready is 1.
REQ-031 n_loads and n_stores SHALL increment by 1 per accepted load and store respectively, and SHALL saturate at 16'hFFFF.
REQ-032 req_half=0 SHALL ignore req_hi and req_signed.

Reset
REQ-033 Asserting reset SHALL immediately force state=IDLE; resp_valid, resp_rdata, resp_tag, mem_wr_enable, mem_wr_addr, mem_wr_data, n_loads and n_stores SHALL all be 0.
REQ-034 Reset asserted during WRITE SHALL drop the write (mem_wr_enable low at once), and no partial merge SHALL persist.
REQ-035 After reset deassertion, req_ready SHALL be 1 in the first cycle.

Structure
REQ-036 A shared package SHALL hold ADDR_W, DATA_W, TAG_W defaults and the IDLE/WRITE state encoding.
REQ-037 Half-word extract, extend and merge SHALL live in one combinational sub-module, lsu_half_align.

Verification
REQ-038 The bench SHALL cover: word store addr 9'h010 data 32'hDEADBEEF -> mem_wr_enable high exactly 1 cycle, req_ready low that cycle, n_stores=1.
REQ-039 The bench SHALL cover: load addr 9'h010 tag 4'h3 immediately after that store -> resp next edge, rdata 32'hDEADBEEF, tag 3.
REQ-040 The bench SHALL cover: half store hi=1 data 16'h8001 to a word holding 32'hDEADBEEF -> write data 32'h8001BEEF; signed half load hi=1 -> 32'hFFFF8001, unsigned -> 32'h00008001.
REQ-041 The bench SHALL cover: resp_ready held 0 for 5 cycles with req_valid=1 -> req_ready stays 0 and resp stays stable, then one load accepted per cycle after release.
REQ-042 The bench SHALL cover: reset asserted mid-WRITE -> mem_wr_enable 0 immediately, all outputs 0, target word unchanged.
REQ-043 The bench SHALL cover: 65536 accepted loads -> n_loads saturates at 16'hFFFF.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared widths, FSM encoding and counter helper for the load/store unit.
// No ports: imported by the interface, the aligner and the top.
package load_store_unit_pkg;

  localparam int LSU_ADDR_W = 9;
  localparam int LSU_DATA_W = 32;
  localparam int LSU_TAG_W  = 4;
  localparam int LSU_CNT_W  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } lsu_state_e;

  function automatic logic [LSU_CNT_W-1:0] sat_inc(
    input logic [LSU_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake bundle of the load/store unit.
// slave: LSU side; master: requester/consumer side.
interface load_store_unit_if
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W,
  parameter int TAG_W  = LSU_TAG_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_half;
  logic              req_hi;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_tag;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic [TAG_W-1:0]  resp_tag;

  modport slave (
    input  req_valid, req_write, req_half,
    input  req_hi, req_signed, req_addr,
    input  req_wdata, req_tag, resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_tag
  );

  modport master (
    output req_valid, req_write, req_half,
    output req_hi, req_signed, req_addr,
    output req_wdata, req_tag, resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_tag
  );

endinterface

// File: rtl/lsu_half_align.sv
// Half-word extract/extend for loads and merge for stores (combinational).
// Ports: word, wdata, hi, sext in; ld_half, st_merge out.
module lsu_half_align
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic [DATA_W-1:0] word,
  input  logic [15:0]       wdata,
  input  logic              hi,
  input  logic              sext,
  output logic [DATA_W-1:0] ld_half,
  output logic [DATA_W-1:0] st_merge
);

  logic [15:0] half;

  assign half = hi ? word[31:16] : word[15:0];

  assign ld_half = {
    {(DATA_W-16){sext & half[15]}},
    half
  };

  always_comb begin
    st_merge = word;
    if (hi) st_merge[31:16] = wdata;
    else    st_merge[15:0]  = wdata;
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: 1-cycle loads, 2-cycle (RMW for halves) stores.
// Ports: clock, reset, bus (slave), memory rd/wr ports, n_loads/n_stores.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W,
  parameter int TAG_W  = LSU_TAG_W
) (
  input  logic                 clock,
  input  logic                 reset,
  load_store_unit_if.slave     bus,
  output logic [ADDR_W-1:0]    mem_rd_addr,
  input  logic [DATA_W-1:0]    mem_rd_data,
  output logic [ADDR_W-1:0]    mem_wr_addr,
  output logic [DATA_W-1:0]    mem_wr_data,
  output logic                 mem_wr_enable,
  output logic [LSU_CNT_W-1:0] n_loads,
  output logic [LSU_CNT_W-1:0] n_stores
);

  lsu_state_e        state;
  logic              rv;
  logic [DATA_W-1:0] rdata;
  logic [TAG_W-1:0]  tag;
  logic              ready;
  logic              ld_acc;
  logic              st_acc;
  logic [DATA_W-1:0] ld_half;
  logic [DATA_W-1:0] st_merge;

  lsu_half_align #(.DATA_W(DATA_W)) u_align (
    .word     (mem_rd_data),
    .wdata    (bus.req_wdata[15:0]),
    .hi       (bus.req_hi),
    .sext     (bus.req_signed),
    .ld_half  (ld_half),
    .st_merge (st_merge)
  );

  // Reads are addressed straight from the request so
  // loads and half-store merges see the word this cycle.
  assign mem_rd_addr = bus.req_addr;

  assign ready  = (state == IDLE) &&
                  (!rv || bus.resp_ready);
  assign ld_acc = bus.req_valid && ready &&
                  !bus.req_write;
  assign st_acc = bus.req_valid && ready &&
                  bus.req_write;

  assign bus.req_ready  = ready;
  assign bus.resp_valid = rv;
  assign bus.resp_rdata = rdata;
  assign bus.resp_tag   = tag;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rv            <= 1'b0;
      rdata         <= '0;
      tag           <= '0;
      mem_wr_enable <= 1'b0;
      mem_wr_addr   <= '0;
      mem_wr_data   <= '0;
      n_loads       <= '0;
      n_stores      <= '0;
    end else begin
      if (rv && bus.resp_ready) rv <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            ld_acc: begin
              rv      <= 1'b1;
              rdata   <= bus.req_half ?
                         ld_half : mem_rd_data;
              tag     <= bus.req_tag;
              n_loads <= sat_inc(n_loads);
            end
            st_acc: begin
              mem_wr_addr   <= bus.req_addr;
              mem_wr_data   <= bus.req_half ?
                               st_merge : bus.req_wdata;
              mem_wr_enable <= 1'b1;
              n_stores      <= sat_inc(n_stores);
              state         <= WRITE;
            end
            default: ;
          endcase
        end
        WRITE: begin
          mem_wr_enable <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
